// File: rtl/axi_ddr3_tester.sv
// AXI4 write/read-back traffic generator: writes NUM_BURSTS incrementing-pattern bursts,
// reads them back and counts data, response, ID and rlast framing errors.
module axi_ddr3_tester #(
    parameter int unsigned              ADDRS        = 25,
    parameter int unsigned              WIDTH        = 32,
    parameter int unsigned              MASKS        = 4,
    parameter int unsigned              AXI_ID_WIDTH = 4,
    parameter logic [AXI_ID_WIDTH-1:0]  TEST_ID      = 4'h5,
    parameter int unsigned              BASE_ADDR    = 0,
    parameter int unsigned              BURST_LEN    = 16,
    parameter int unsigned              NUM_BURSTS   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    fail_o,
    output logic [15:0]             err_count_o,

    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [ADDRS-1:0]        axi_awaddr_o,
    output logic [AXI_ID_WIDTH-1:0] axi_awid_o,
    output logic [7:0]              axi_awlen_o,
    output logic [1:0]              axi_awburst_o,

    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    output logic                    axi_wlast_o,
    output logic [MASKS-1:0]        axi_wstrb_o,
    output logic [WIDTH-1:0]        axi_wdata_o,

    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o,
    input  logic [1:0]              axi_bresp_i,
    input  logic [AXI_ID_WIDTH-1:0] axi_bid_i,

    output logic                    axi_arvalid_o,
    input  logic                    axi_arready_i,
    output logic [ADDRS-1:0]        axi_araddr_o,
    output logic [AXI_ID_WIDTH-1:0] axi_arid_o,
    output logic [7:0]              axi_arlen_o,
    output logic [1:0]              axi_arburst_o,

    input  logic                    axi_rvalid_i,
    output logic                    axi_rready_o,
    input  logic                    axi_rlast_i,
    input  logic [1:0]              axi_rresp_i,
    input  logic [AXI_ID_WIDTH-1:0] axi_rid_i,
    input  logic [WIDTH-1:0]        axi_rdata_i
);

    localparam logic [7:0]       LastBeat  = 8'(BURST_LEN - 1);
    localparam logic [7:0]       LastBurst = 8'(NUM_BURSTS - 1);
    localparam logic [ADDRS-1:0] BaseAddr  = ADDRS'(BASE_ADDR);
    localparam logic [ADDRS-1:0] Stride    = ADDRS'(BURST_LEN);

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData, StDone
    } state_e;

    state_e      state_q;
    logic [7:0]  burst_q;
    logic [7:0]  beat_q;
    logic [15:0] idx_q;   // global beat index n, wraps at 2^16

    logic        b_bad;
    logic        r_bad;
    logic        err_hit;
    logic [15:0] err_next;

    function automatic logic [31:0] pattern(input logic [15:0] n);
        return {~n, n};
    endfunction

    assign axi_awid_o    = TEST_ID;
    assign axi_awlen_o   = LastBeat;
    assign axi_awburst_o = 2'b01;
    assign axi_wstrb_o   = '1;
    assign axi_arid_o    = TEST_ID;
    assign axi_arlen_o   = LastBeat;
    assign axi_arburst_o = 2'b01;

    // One error per faulty handshake, regardless of how many fields are wrong.
    always_comb begin
        b_bad = (axi_bresp_i != 2'b00) || (axi_bid_i != TEST_ID);
        r_bad = (axi_rdata_i != pattern(idx_q)) || (axi_rresp_i != 2'b00)
             || (axi_rid_i != TEST_ID) || (axi_rlast_i != (beat_q == LastBeat));
        err_hit = 1'b0;
        if (state_q == StWrResp && axi_bready_o && axi_bvalid_i) err_hit = b_bad;
        if (state_q == StRdData && axi_rready_o && axi_rvalid_i) err_hit = r_bad;
        err_next = (err_hit && err_count_o != 16'hFFFF) ? err_count_o + 16'd1 : err_count_o;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            burst_q       <= '0;
            beat_q        <= '0;
            idx_q         <= '0;
            axi_awvalid_o <= 1'b0;
            axi_awaddr_o  <= '0;
            axi_wvalid_o  <= 1'b0;
            axi_wlast_o   <= 1'b0;
            axi_wdata_o   <= '0;
            axi_bready_o  <= 1'b0;
            axi_arvalid_o <= 1'b0;
            axi_araddr_o  <= '0;
            axi_rready_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            fail_o        <= 1'b0;
            err_count_o   <= '0;
        end else begin
            err_count_o <= err_next;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q       <= StWrAddr;
                        burst_q       <= '0;
                        beat_q        <= '0;
                        idx_q         <= '0;
                        axi_awvalid_o <= 1'b1;
                        axi_awaddr_o  <= BaseAddr;
                        busy_o        <= 1'b1;
                        done_o        <= 1'b0;
                        fail_o        <= 1'b0;
                        err_count_o   <= '0;
                    end
                end
                StWrAddr: begin
                    if (axi_awvalid_o && axi_awready_i) begin
                        axi_awvalid_o <= 1'b0;
                        axi_wvalid_o  <= 1'b1;
                        axi_wlast_o   <= (LastBeat == 8'd0);
                        axi_wdata_o   <= pattern(idx_q);
                        beat_q        <= '0;
                        state_q       <= StWrData;
                    end
                end
                StWrData: begin
                    if (axi_wvalid_o && axi_wready_i) begin
                        idx_q <= idx_q + 16'd1;
                        if (axi_wlast_o) begin
                            axi_wvalid_o <= 1'b0;
                            axi_wlast_o  <= 1'b0;
                            axi_bready_o <= 1'b1;
                            state_q      <= StWrResp;
                        end else begin
                            beat_q      <= beat_q + 8'd1;
                            axi_wdata_o <= pattern(idx_q + 16'd1);
                            axi_wlast_o <= ((beat_q + 8'd1) == LastBeat);
                        end
                    end
                end
                StWrResp: begin
                    if (axi_bready_o && axi_bvalid_i) begin
                        axi_bready_o <= 1'b0;
                        if (burst_q == LastBurst) begin
                            burst_q       <= '0;
                            idx_q         <= '0;
                            axi_araddr_o  <= BaseAddr;
                            axi_arvalid_o <= 1'b1;
                            state_q       <= StRdAddr;
                        end else begin
                            burst_q       <= burst_q + 8'd1;
                            axi_awaddr_o  <= axi_awaddr_o + Stride;
                            axi_awvalid_o <= 1'b1;
                            state_q       <= StWrAddr;
                        end
                    end
                end
                StRdAddr: begin
                    if (axi_arvalid_o && axi_arready_i) begin
                        axi_arvalid_o <= 1'b0;
                        axi_rready_o  <= 1'b1;
                        beat_q        <= '0;
                        state_q       <= StRdData;
                    end
                end
                StRdData: begin
                    // Burst length is set by the beat counter, not by rlast.
                    if (axi_rready_o && axi_rvalid_i) begin
                        idx_q <= idx_q + 16'd1;
                        if (beat_q == LastBeat) begin
                            axi_rready_o <= 1'b0;
                            if (burst_q == LastBurst) begin
                                state_q <= StDone;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                                fail_o  <= (err_next != 16'd0);
                            end else begin
                                burst_q       <= burst_q + 8'd1;
                                axi_araddr_o  <= axi_araddr_o + Stride;
                                axi_arvalid_o <= 1'b1;
                                state_q       <= StRdAddr;
                            end
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ddr3_tester.sv
// Bench for axi_ddr3_tester: reactive AXI slave with memory, scoreboard of expected
// addresses/write data, fault injection, mid-pass reset and a single-beat configuration.
module tb_axi_ddr3_tester;

    localparam logic [3:0] TestId = 4'h5;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic        busy_o, done_o, fail_o;
    logic [15:0] err_count_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [24:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_wvalid_o, axi_wready_i, axi_wlast_o;
    logic [3:0]  axi_wstrb_o;
    logic [31:0] axi_wdata_o;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i;
    logic [3:0]  axi_bid_i;
    logic        axi_arvalid_o, axi_arready_i;
    logic [24:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i, axi_rready_o, axi_rlast_i;
    logic [1:0]  axi_rresp_i;
    logic [3:0]  axi_rid_i;
    logic [31:0] axi_rdata_i;

    // Second instance: single-beat, single-burst configuration with tied-off slave.
    logic        start1, busy1, done1, fail1;
    logic [15:0] err1;
    logic        awvalid1, awready1, wvalid1, wready1, wlast1, bvalid1, bready1;
    logic        arvalid1, arready1, rvalid1, rready1, rlast1;
    logic [24:0] awaddr1, araddr1;
    logic [3:0]  awid1, arid1, wstrb1, bid1, rid1;
    logic [7:0]  awlen1, arlen1;
    logic [1:0]  awburst1, arburst1, bresp1, rresp1;
    logic [31:0] wdata1, rdata1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Slave configuration and bookkeeping
    bit          stall;
    int          corrupt_n, bresp_burst, rid_beat;
    int          wbeats, rbeats, bcnt, b_pend, wk, rk, rlen;
    logic [24:0] wr_base;
    logic [24:0] rq[$];
    logic [31:0] mem [256];
    bit          b_fire, r_fire, aw_hold_v, w_hold_v;
    logic [24:0] aw_hold;
    logic [32:0] w_hold;

    // Scoreboard
    logic [24:0] exp_aw[$];
    logic [24:0] exp_ar[$];
    logic [31:0] exp_w[$];

    axi_ddr3_tester dut (
        .clock(clock), .reset(reset), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .err_count_o(err_count_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o), .axi_awlen_o(axi_awlen_o),
        .axi_awburst_o(axi_awburst_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wlast_o(axi_wlast_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wdata_o(axi_wdata_o),
        .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i),
        .axi_bid_i(axi_bid_i),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o),
        .axi_arburst_o(axi_arburst_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o), .axi_rlast_i(axi_rlast_i),
        .axi_rresp_i(axi_rresp_i), .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i)
    );

    axi_ddr3_tester #(.BURST_LEN(1), .NUM_BURSTS(1)) dut1 (
        .clock(clock), .reset(reset), .start_i(start1),
        .busy_o(busy1), .done_o(done1), .fail_o(fail1), .err_count_o(err1),
        .axi_awvalid_o(awvalid1), .axi_awready_i(awready1), .axi_awaddr_o(awaddr1),
        .axi_awid_o(awid1), .axi_awlen_o(awlen1), .axi_awburst_o(awburst1),
        .axi_wvalid_o(wvalid1), .axi_wready_i(wready1), .axi_wlast_o(wlast1),
        .axi_wstrb_o(wstrb1), .axi_wdata_o(wdata1),
        .axi_bvalid_i(bvalid1), .axi_bready_o(bready1), .axi_bresp_i(bresp1),
        .axi_bid_i(bid1),
        .axi_arvalid_o(arvalid1), .axi_arready_i(arready1), .axi_araddr_o(araddr1),
        .axi_arid_o(arid1), .axi_arlen_o(arlen1), .axi_arburst_o(arburst1),
        .axi_rvalid_i(rvalid1), .axi_rready_o(rready1), .axi_rlast_i(rlast1),
        .axi_rresp_i(rresp1), .axi_rid_i(rid1), .axi_rdata_i(rdata1)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic draw();
        return stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic slave_clear();
        axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_arready_i = 1'b0;
        axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00; axi_bid_i = 4'h0;
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0; axi_rresp_i = 2'b00;
        axi_rid_i = 4'h0; axi_rdata_i = 32'h0;
        b_fire = 1'b0; r_fire = 1'b0; aw_hold_v = 1'b0; w_hold_v = 1'b0;
        wbeats = 0; rbeats = 0; bcnt = 0; b_pend = 0; wk = 0; rk = 0; rlen = 0;
        wr_base = '0;
        rq.delete();
    endtask

    // Reactive slave: drives at the negedge, so handshakes for the next posedge are known here.
    initial begin
        slave_clear();
        forever begin
            @(negedge clock);
            if (reset) begin
                slave_clear();
                continue;
            end
            if (b_fire) axi_bvalid_i = 1'b0;
            if (r_fire) axi_rvalid_i = 1'b0;
            axi_awready_i = draw();
            axi_wready_i  = draw();
            axi_arready_i = draw();
            if (!axi_bvalid_i && b_pend > 0 && draw()) begin
                axi_bvalid_i = 1'b1;
                axi_bresp_i  = (bcnt == bresp_burst) ? 2'b10 : 2'b00;
                axi_bid_i    = TestId;
            end
            if (!axi_rvalid_i && rq.size() > 0 && draw()) begin
                axi_rdata_i = mem[8'(rq[0] + 25'(rk))];
                if (rbeats == corrupt_n) axi_rdata_i[0] = ~axi_rdata_i[0];
                axi_rid_i    = (rbeats == rid_beat) ? 4'h0 : TestId;
                axi_rresp_i  = 2'b00;
                axi_rlast_i  = (rk == rlen);
                axi_rvalid_i = 1'b1;
            end
            if (aw_hold_v) check("aw_stable", {axi_awvalid_o, axi_awaddr_o}, {1'b1, aw_hold});
            if (w_hold_v) check("w_stable", {axi_wvalid_o, axi_wlast_o, axi_wdata_o}, {1'b1, w_hold});
            aw_hold_v = axi_awvalid_o && !axi_awready_i;
            aw_hold   = axi_awaddr_o;
            w_hold_v  = axi_wvalid_o && !axi_wready_i;
            w_hold    = {axi_wlast_o, axi_wdata_o};
            if (axi_awvalid_o && axi_awready_i) begin
                check("awaddr", axi_awaddr_o, exp_aw.size() > 0 ? exp_aw.pop_front() : 'x);
                check("aw_fields", {axi_awid_o, axi_awlen_o, axi_awburst_o}, {TestId, 8'd15, 2'b01});
                wr_base = axi_awaddr_o;
                wk = 0;
            end
            if (axi_wvalid_o && axi_wready_i) begin
                check("wdata", {axi_wstrb_o, axi_wdata_o},
                      {4'hF, exp_w.size() > 0 ? exp_w.pop_front() : 32'hx});
                check("wlast", axi_wlast_o, wk == 15);
                mem[8'(wr_base + 25'(wk))] = axi_wdata_o;
                wbeats++;
                wk++;
                if (axi_wlast_o) begin
                    wk = 0;
                    b_pend++;
                end
            end
            b_fire = axi_bvalid_i && axi_bready_o;
            if (b_fire) begin
                b_pend--;
                bcnt++;
            end
            if (axi_arvalid_o && axi_arready_i) begin
                check("araddr", axi_araddr_o, exp_ar.size() > 0 ? exp_ar.pop_front() : 'x);
                check("ar_fields", {axi_arid_o, axi_arlen_o, axi_arburst_o}, {TestId, 8'd15, 2'b01});
                rq.push_back(axi_araddr_o);
                rlen = int'(axi_arlen_o);
                rk = 0;
            end
            r_fire = axi_rvalid_i && axi_rready_o;
            if (r_fire) begin
                rbeats++;
                if (rk == rlen) begin
                    void'(rq.pop_front());
                    rk = 0;
                end else begin
                    rk++;
                end
            end
        end
    end

    task automatic push_expected();
        logic [15:0] n16;
        exp_aw.delete(); exp_ar.delete(); exp_w.delete();
        for (int b = 0; b < 4; b++) begin
            exp_aw.push_back(25'(b * 16));
            exp_ar.push_back(25'(b * 16));
        end
        for (int n = 0; n < 64; n++) begin
            n16 = 16'(n);
            exp_w.push_back({~n16, n16});
        end
    endtask

    task automatic do_start();
        @(posedge clock); #1 start_i = 1'b1;
        @(posedge clock); #1 start_i = 1'b0;
        check("start_aw", {axi_awvalid_o, busy_o, done_o, err_count_o}, {1'b1, 1'b1, 1'b0, 16'd0});
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clock); #1;
            if (done_o) break;
        end
    endtask

    task automatic run_pass(input string name, input bit st, input int cn, input int bb,
                            input int rb, input int exp_err);
        stall = st; corrupt_n = cn; bresp_burst = bb; rid_beat = rb;
        slave_clear();
        push_expected();
        do_start();
        wait_done(8000);
        check({name, "_done"}, done_o, 1'b1);
        check({name, "_err"}, err_count_o, 16'(exp_err));
        check({name, "_fail"}, fail_o, exp_err != 0);
        check({name, "_busy"}, busy_o, 1'b0);
        check({name, "_wbeats"}, wbeats, 64);
        check({name, "_rbeats"}, rbeats, 64);
        check({name, "_sb_left"}, exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    endtask

    initial begin
        awready1 = 1'b1; wready1 = 1'b1; arready1 = 1'b1;
        bvalid1 = 1'b1; bresp1 = 2'b00; bid1 = TestId;
        rvalid1 = 1'b1; rlast1 = 1'b1; rresp1 = 2'b00; rid1 = TestId; rdata1 = 32'hFFFF0000;
        start1 = 1'b0;
        stall = 1'b0; corrupt_n = -1; bresp_burst = -1; rid_beat = -1;
        reset = 1'b1;
        start_i = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valids", {axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o}, 5'b0);
        check("rst_status", {busy_o, done_o, fail_o, err_count_o}, 19'd0);
        check("rst_addr", {axi_awaddr_o, axi_araddr_o, axi_wdata_o}, 82'd0);
        check("rst_dut1", {awvalid1, wvalid1, busy1, done1, err1}, 20'd0);
        reset = 1'b0;

        run_pass("ideal", 1'b0, -1, -1, -1, 0);
        run_pass("stall", 1'b1, -1, -1, -1, 0);
        run_pass("corrupt37", 1'b0, 37, -1, -1, 1);
        run_pass("bresp_rid", 1'b1, -1, 2, 3, 2);

        // Abort a pass while write beat 5 is on the bus
        stall = 1'b0; corrupt_n = -1; bresp_burst = -1; rid_beat = -1;
        slave_clear();
        push_expected();
        do_start();
        for (int i = 0; i < 200 && wbeats < 5; i++) @(posedge clock);
        #1;
        check("midrst_beats", wbeats, 5);
        check("midrst_pre", {axi_wvalid_o, busy_o}, 2'b11);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_valids", {axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o,
                                axi_rready_o, busy_o}, 6'd0);
        reset = 1'b0;
        run_pass("after_rst", 1'b0, -1, -1, -1, 0);

        // Single-beat configuration
        @(posedge clock); #1 start1 = 1'b1;
        @(posedge clock); #1 start1 = 1'b0;
        check("bl1_aw", {awvalid1, awlen1, awaddr1}, {1'b1, 8'd0, 25'd0});
        @(posedge clock); #1;
        check("bl1_w", {wvalid1, wlast1, wstrb1, wdata1}, {1'b1, 1'b1, 4'hF, 32'hFFFF0000});
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (done1) break;
        end
        check("bl1_done", {done1, fail1, busy1, err1}, {1'b1, 1'b0, 1'b0, 16'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_ddr3_tester.md
# axi_ddr3_tester

AXI4 initiator that exercises the `axi_ddr3_lite` slave port: it writes a fixed number of incrementing-pattern bursts into a DDR3 region, reads them back, and checks data, response codes, IDs and `rlast` framing. It sits on the AXI side of the controller. It is used for bring-up on hardware and as a self-checking traffic source in system simulation. All transfers are single-outstanding, INCR, 4-byte beats.

## Interface
- `ADDRS`, 25: AXI address width, in word (beat) units, matching the controller.
- `WIDTH`, 32: data width; fixed at 32.
- `MASKS`, 4: strobe width (`WIDTH/8`).
- `AXI_ID_WIDTH`, 4: ID width.
- `TEST_ID`, 4'h5: ID driven on `awid`/`arid` and expected on `bid`/`rid`.
- `BASE_ADDR`, 0: first word address of the test region.
- `BURST_LEN`, 16: beats per burst, 1..256.
- `NUM_BURSTS`, 4: bursts per pass, 1..256.

Ports:
- `clock` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `start_i` in 1: single-cycle pulse that begins a pass. Ignored while `busy_o` is high.
- `busy_o` out 1: a pass is in progress.
- `done_o` out 1: pass finished; held until the next accepted start.
- `fail_o` out 1: at least one error in the last pass; valid while `done_o` is high.
- `err_count_o` out 16: errors counted in the current or last pass; saturates at 16'hFFFF.
- `axi_awvalid_o`/`axi_awready_i`/`axi_awaddr_o[ADDRS]`/`axi_awid_o`/`axi_awlen_o[8]`/`axi_awburst_o[2]`: write-address channel.
- `axi_wvalid_o`/`axi_wready_i`/`axi_wlast_o`/`axi_wstrb_o[MASKS]`/`axi_wdata_o[WIDTH]`: write-data channel.
- `axi_bvalid_i`/`axi_bready_o`/`axi_bresp_i[2]`/`axi_bid_i`: write-response channel.
- `axi_arvalid_o`/`axi_arready_i`/`axi_araddr_o`/`axi_arid_o`/`axi_arlen_o[8]`/`axi_arburst_o[2]`: read-address channel.
- `axi_rvalid_i`/`axi_rready_o`/`axi_rlast_i`/`axi_rresp_i[2]`/`axi_rid_i`/`axi_rdata_i[WIDTH]`: read-data channel.

## Operation
- FSM states: IDLE → WR_ADDR → WR_DATA → WR_RESP → (next burst: WR_ADDR | last burst: RD_ADDR) → RD_DATA → (next burst: RD_ADDR | last burst: DONE) → DONE.
- DONE → WR_ADDR on `start_i`, which clears `err_count_o`, `fail_o` and `done_o`.
- Burst counter `b` runs 0..NUM_BURSTS-1. Beat counter `k` runs 0..BURST_LEN-1.
- Global beat index: `n = b*BURST_LEN + k`, 16 bits, wraps modulo 2^16.
- Address for burst b: `BASE_ADDR + b*BURST_LEN`, truncated to ADDRS bits.
- Constant fields: `awlen`/`arlen` = BURST_LEN-1, `awburst`/`arburst` = 2'b01, `wstrb` = all ones.
- Pattern: `wdata = {~n[15:0], n[15:0]}`. Read data is compared against the same function of the read-side n.
- `wlast` is high on beat k = BURST_LEN-1 only.
- Errors: +1 each, saturating:
  - `bresp != 2'b00` or `bid != TEST_ID` at each B handshake;
  - per R beat: data mismatch, `rresp != 2'b00`, `rid != TEST_ID`, or `rlast` != (k == BURST_LEN-1).
  - A beat with several faults counts once.
- `fail_o` = (`err_count_o != 0`), registered on entry to DONE.
- `busy_o` is high in every state except IDLE and DONE.

## Timing
- Reset values: all valid/ready outputs 0, `busy_o`/`done_o`/`fail_o` 0, `err_count_o` 0, counters 0, state IDLE. Address/data outputs are 0.
- Reset asserted mid-pass aborts the pass at that edge. No further AXI handshakes complete.
- `start_i` sampled in IDLE/DONE: `axi_awvalid_o` rises on the next cycle.
- Handshake occurs on any cycle where valid && ready.
  - `awvalid`/`arvalid` are held with stable payload until accepted, then drop the following cycle.
  - `wvalid` rises the cycle after AW acceptance and stays high across beats. Data advances on each accepted beat. `wvalid` drops after the `wlast` handshake.
  - `bready_o` is 1 throughout WR_RESP. `rready_o` is 1 throughout RD_DATA. Both are 0 elsewhere.
- Back-to-back: the next AW/AR is issued the cycle after the B handshake or the final R beat.
- Last R beat with `rlast` low counts an error; RD_DATA still exits on k = BURST_LEN-1.
- Early `rlast` counts an error; the remaining beats are still consumed.
- `done_o` rises the cycle after the final R handshake.

## Test plan
- Ideal slave model (always ready, zero-wait, correct echo), defaults → `done_o`=1, `fail_o`=0, `err_count_o`=0; 64 W beats and 64 R beats observed; awaddr sequence 0,16,32,48.
- Random ready/valid stalls (50%) on all channels → same result. No payload changes while valid && !ready.
- Slave corrupts read beat n=37 (bit 0 flipped) → `err_count_o`=1, `fail_o`=1.
- `bresp`=2'b10 on burst 2 and `rid`=4'h0 on one beat of burst 0 → `err_count_o`=2.
- Reset asserted during WR_DATA beat 5 → next cycle all valids 0, `busy_o`=0. A subsequent start completes cleanly.
- BURST_LEN=1, NUM_BURSTS=1 → `awlen`=0, a single beat with `wlast`=1, `wdata`=32'hFFFF0000.
